// File: rtl/led7seg_595_frame_receiver.sv
// Receive-side monitor for the 74HC595 seven-segment serial link: rebuilds each
// latched 16-bit frame from sclk/rclk/dio and decodes it into per-digit BCD.
module led7seg_595_frame_receiver #(
  parameter int FRAME_W    = 16,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    rclk,
  input  logic                    dio,
  output logic [FRAME_W-1:0]      frame,
  output logic                    frame_vld,
  output logic                    len_err,
  output logic                    sel_err,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid
);

  localparam logic [4:0]            CNT_MAX  = 5'd31;
  localparam logic [4:0]            CNT_FULL = 5'(FRAME_W);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  // Synchroniser bit order: [2] sclk, [1] rclk, [0] dio.
  logic [2:0]              sync1_q, sync1_d;
  logic [2:0]              sync2_q, sync2_d;
  logic [1:0]              prev_q, prev_d;
  logic [FRAME_W-1:0]      shreg_q, shreg_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic                    frame_vld_q, frame_vld_d;
  logic                    len_err_q, len_err_d;
  logic                    sel_err_q, sel_err_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;

  logic                    sclk_rise;
  logic                    rclk_rise;
  logic                    dio_s;
  logic [4:0]              cnt_shift;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    sel_onehot;
  logic [4:0]              dec;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} to {recognised, bcd}; dp ignored.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [7:0] p;
    p = pat | 8'h80;
    case (p)
      8'hC0:   seg_decode = {1'b1, 4'd0};
      8'hF9:   seg_decode = {1'b1, 4'd1};
      8'hA4:   seg_decode = {1'b1, 4'd2};
      8'hB0:   seg_decode = {1'b1, 4'd3};
      8'h99:   seg_decode = {1'b1, 4'd4};
      8'h92:   seg_decode = {1'b1, 4'd5};
      8'h82:   seg_decode = {1'b1, 4'd6};
      8'hF8:   seg_decode = {1'b1, 4'd7};
      8'h80:   seg_decode = {1'b1, 4'd8};
      8'h90:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'hF};
    endcase
  endfunction

  always_comb begin
    sync1_d   = {sclk, rclk, dio};
    sync2_d   = sync1_q;
    prev_d    = sync2_q[2:1];
    sclk_rise = sync2_q[2] & ~prev_q[1];
    rclk_rise = sync2_q[1] & ~prev_q[0];
    dio_s     = sync2_q[0];
  end

  // A coincident shift and latch: the latch sees the post-shift register and count.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_shift   = cnt_q;
    frame_d     = frame_q;
    frame_vld_d = 1'b0;
    len_err_d   = 1'b0;
    if (sclk_rise) begin
      shreg_d   = {shreg_q[FRAME_W-2:0], dio_s};
      cnt_shift = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
    end
    cnt_d = cnt_shift;
    if (rclk_rise) begin
      frame_d     = shreg_d;
      frame_vld_d = 1'b1;
      len_err_d   = (cnt_shift != CNT_FULL);
      cnt_d       = 5'd0;
    end
  end

  always_comb begin
    sel        = frame_q[NUM_DIGITS-1:0];
    sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    dec        = seg_decode(frame_q[FRAME_W-1 -: 8]);
    digits_d   = digits_q;
    valid_d    = valid_q;
    sel_err_d  = 1'b0;
    if (frame_vld_q) begin
      if (sel_onehot) begin
        for (int n = 0; n < NUM_DIGITS; n++) begin
          if (sel[n]) begin
            digits_d[4*n +: 4] = dec[3:0];
            valid_d[n]         = dec[4];
          end
        end
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      frame_vld_q <= 1'b0;
      len_err_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      digits_q    <= '1;
      valid_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      frame_vld_q <= frame_vld_d;
      len_err_q   <= len_err_d;
      sel_err_q   <= sel_err_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
    end
  end

  assign frame       = frame_q;
  assign frame_vld   = frame_vld_q;
  assign len_err     = len_err_q;
  assign sel_err     = sel_err_q;
  assign digits_bcd  = digits_q;
  assign digit_valid = valid_q;

endmodule

// File: tb/tb_led7seg_595_frame_receiver.sv
// Bench for led7seg_595_frame_receiver: drives the serial link and compares
// against a bit-history / digit-table model of the link.
module tb_led7seg_595_frame_receiver;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        dio  = 1'b0;
  logic [15:0] frame;
  logic        frame_vld;
  logic        len_err;
  logic        sel_err;
  logic [31:0] digits_bcd;
  logic [7:0]  digit_valid;

  int checks = 0;
  int errors = 0;

  led7seg_595_frame_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .rclk       (rclk),
    .dio        (dio),
    .frame      (frame),
    .frame_vld  (frame_vld),
    .len_err    (len_err),
    .sel_err    (sel_err),
    .digits_bcd (digits_bcd),
    .digit_valid(digit_valid)
  );

  always #4 clk = ~clk;

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Model state: every bit shifted since reset, bits since last latch, digit table.
  logic        hist_q[$];
  int          since_latch = 0;
  logic [3:0]  m_bcd[8];
  logic        m_valid[8];
  logic [15:0] exp_q[$];

  // Pulse monitor.
  int   vld_cnt = 0, len_cnt = 0, sel_cnt = 0, bad_pulse = 0;
  logic vld_prev = 1'b0, sel_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_vld && vld_prev) bad_pulse++;
    if (sel_err && sel_prev) bad_pulse++;
    if (len_err && !frame_vld) bad_pulse++;
    if (frame_vld) vld_cnt++;
    if (len_err) len_cnt++;
    if (sel_err) sel_cnt++;
    vld_prev = frame_vld;
    sel_prev = sel_err;
  end

  function automatic logic [4:0] seg_model(input logic [7:0] pat);
    logic [4:0] r;
    r = {1'b0, 4'hF};
    for (int i = 0; i < 10; i++)
      if (SEG_TAB[i] == (pat | 8'h80)) r = {1'b1, 4'(i)};
    return r;
  endfunction

  function automatic logic [15:0] model_frame();
    logic [15:0] f;
    int base;
    f = '0;
    base = hist_q.size() - 16;
    for (int i = 0; i < 16; i++)
      if (base + i >= 0) f[15-i] = hist_q[base+i];
    return f;
  endfunction

  function automatic logic [31:0] exp_digits();
    logic [31:0] v;
    for (int n = 0; n < 8; n++) v[4*n +: 4] = m_bcd[n];
    return v;
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int n = 0; n < 8; n++) v[n] = m_valid[n];
    return v;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    exp_q.delete();
    since_latch = 0;
    for (int n = 0; n < 8; n++) begin
      m_bcd[n]   = 4'hF;
      m_valid[n] = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    dio = b;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    hist_q.push_back(b);
    since_latch++;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Latch (optionally shifting one more bit on the same edge) and check the
  // exact N+1/N+2/N+3 timing of every output.
  task automatic latch_check(input logic simul, input logic b);
    logic [15:0] f, e;
    logic        exp_len, exp_sel;
    logic [4:0]  d;
    if (simul) begin
      @(negedge clk);
      dio = b;
      repeat (2) @(negedge clk);
      hist_q.push_back(b);
      since_latch++;
    end
    f       = model_frame();
    exp_len = (since_latch != 16);
    exp_sel = ($countones(f[7:0]) != 1);
    exp_q.push_back(f);
    @(negedge clk);
    rclk = 1'b1;
    if (simul) sclk = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_vld !== 1'b0) begin errors++; $display("FAIL vld_at_n: got %b want 0", frame_vld); end
    @(negedge clk);
    checks++;
    if (frame_vld !== 1'b0) begin errors++; $display("FAIL vld_at_n1: got %b want 0", frame_vld); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (frame_vld !== 1'b1) begin errors++; $display("FAIL vld_at_n2: got %b want 1", frame_vld); end
    checks++;
    if (frame !== e) begin errors++; $display("FAIL frame: got %h want %h", frame, e); end
    checks++;
    if (len_err !== exp_len) begin errors++; $display("FAIL len_err: got %b want %b (bits %0d)", len_err, exp_len, since_latch); end
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL sel_err_early: got %b want 0", sel_err); end
    if (!exp_sel) begin
      d = seg_model(f[15:8]);
      for (int n = 0; n < 8; n++)
        if (f[n]) begin
          m_bcd[n]   = d[3:0];
          m_valid[n] = d[4];
        end
    end
    since_latch = 0;
    @(negedge clk);
    checks++;
    if (frame_vld !== 1'b0 || len_err !== 1'b0) begin
      errors++; $display("FAIL pulse_width: got vld=%b len=%b want 0 0", frame_vld, len_err);
    end
    checks++;
    if (sel_err !== exp_sel) begin errors++; $display("FAIL sel_err: got %b want %b (frame %h)", sel_err, exp_sel, f); end
    checks++;
    if (digits_bcd !== exp_digits()) begin errors++; $display("FAIL digits_bcd: got %h want %h", digits_bcd, exp_digits()); end
    checks++;
    if (digit_valid !== exp_valid()) begin errors++; $display("FAIL digit_valid: got %h want %h", digit_valid, exp_valid()); end
    rclk = 1'b0;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] f);
    send_bits({48'h0, f}, 16);
    latch_check(1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (frame !== 16'h0 || frame_vld !== 1'b0 || len_err !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got frame=%h vld=%b len=%b sel=%b want 0000 0 0 0", tag, frame, frame_vld, len_err, sel_err);
    end
    checks++;
    if (digits_bcd !== 32'hFFFFFFFF || digit_valid !== 8'h00) begin
      errors++;
      $display("FAIL %s_digits: got %h/%h want ffffffff/00", tag, digits_bcd, digit_valid);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    send_frame(16'h9202);
    checks++;
    if (digits_bcd[7:4] !== 4'd5 || digit_valid !== 8'h02) begin
      errors++; $display("FAIL single_digit: got %h/%h want 5/02", digits_bcd[7:4], digit_valid);
    end
  endtask

  task automatic test_all_digits();
    for (int n = 0; n < 8; n++) send_frame({SEG_TAB[n], 8'(1 << n)});
    checks++;
    if (digits_bcd !== 32'h76543210 || digit_valid !== 8'hFF) begin
      errors++; $display("FAIL all_digits: got %h/%h want 76543210/ff", digits_bcd, digit_valid);
    end
  endtask

  task automatic test_len_err();
    send_bits({48'h0, 16'hA420}, 15);
    latch_check(1'b0, 1'b0);
    send_bits({47'h0, 17'h1_9910}, 17);
    latch_check(1'b0, 1'b0);
    // 48 bits: a wrapping 5-bit counter would read 16 here.
    send_bits({16'h0, 48'h1234_5678_C004}, 48);
    latch_check(1'b0, 1'b0);
  endtask

  task automatic test_sel_err();
    send_frame(16'hC003);
    send_frame(16'hF900);
  endtask

  task automatic test_dp();
    send_frame(16'h0010);
    checks++;
    if (digits_bcd[19:16] !== 4'd8 || digit_valid[4] !== 1'b1) begin
      errors++; $display("FAIL dp_lit: got %h/%b want 8/1", digits_bcd[19:16], digit_valid[4]);
    end
    send_frame(16'hFF10);
    checks++;
    if (digits_bcd[19:16] !== 4'hF || digit_valid[4] !== 1'b0) begin
      errors++; $display("FAIL blank: got %h/%b want f/0", digits_bcd[19:16], digit_valid[4]);
    end
  endtask

  task automatic test_simultaneous();
    send_bits({48'h0, 16'hB040}, 15);
    latch_check(1'b1, 1'b0);
    send_bits({48'h0, 16'h8281}, 15);
    latch_check(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int v0, l0, s0;
    logic [15:0] f;
    logic [4:0]  d;
    send_bits({48'h0, 16'hB008}, 16);
    f  = model_frame();
    v0 = vld_cnt;
    l0 = len_cnt;
    s0 = sel_cnt;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk); rclk = 1'b1;
      @(negedge clk);
      @(negedge clk); rclk = 1'b0;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    d = seg_model(f[15:8]);
    m_bcd[3]   = d[3:0];
    m_valid[3] = d[4];
    since_latch = 0;
    checks++;
    if (vld_cnt - v0 != 4) begin errors++; $display("FAIL b2b_vld: got %0d want 4", vld_cnt - v0); end
    checks++;
    if (len_cnt - l0 != 3) begin errors++; $display("FAIL b2b_len: got %0d want 3", len_cnt - l0); end
    checks++;
    if (sel_cnt - s0 != 0) begin errors++; $display("FAIL b2b_sel: got %0d want 0", sel_cnt - s0); end
    checks++;
    if (frame !== f) begin errors++; $display("FAIL b2b_frame: got %h want %h", frame, f); end
    checks++;
    if (digits_bcd !== exp_digits() || digit_valid !== exp_valid()) begin
      errors++; $display("FAIL b2b_digits: got %h/%h want %h/%h", digits_bcd, digit_valid, exp_digits(), exp_valid());
    end
  endtask

  task automatic test_random();
    logic [7:0]  pat, sel;
    logic [63:0] v;
    int          nb;
    logic        simul;
    for (int it = 0; it < 16; it++) begin
      pat = SEG_TAB[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) pat[7] = 1'b0;
      if ($urandom_range(0, 4) == 0) pat = 8'($urandom);
      sel = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) sel = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : 16;
      simul = ($urandom_range(0, 3) == 0);
      v = {48'h0, pat, sel};
      if (simul) begin
        send_bits(v >> 1, nb - 1);
        latch_check(1'b1, v[0]);
      end else begin
        send_bits(v, nb);
        latch_check(1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_bits({48'h0, 16'h00A5}, 8);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(16'h0601);
    checks++;
    if (frame !== 16'h0601 || digit_valid !== 8'h00) begin
      errors++; $display("FAIL after_reset: got %h/%h want 0601/00", frame, digit_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_all_digits();
    test_len_err();
    test_sel_err();
    test_dp();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    checks++;
    if (bad_pulse != 0) begin errors++; $display("FAIL pulse_shape: got %0d bad pulses want 0", bad_pulse); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
